// File: rtl/ctrl_pkg.sv
// Shared types and constants for the pipelined control decoder.
package ctrl_pkg;

  // Destination-register field width carried in every control bundle.
  localparam int CTRL_RD_W = 5;

  // ALU operation codes.
  localparam logic [2:0] ALU_PASSB = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b011;
  localparam logic [2:0] ALU_MUL   = 3'b100;
  localparam logic [2:0] ALU_LSL   = 3'b101;
  localparam logic [2:0] ALU_LSR   = 3'b110;

  // Opcode patterns on inst[31:21]; '?' bits are don't-care in casez.
  localparam logic [10:0] OP_ADDI = 11'b1001000100?;
  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_MUL  = 11'b10011011000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [10:0] OP_B    = 11'b000101?????;
  localparam logic [10:0] OP_CBZ  = 11'b10110100???;
  localparam logic [10:0] OP_BLT  = 11'b01010100???;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  // Control bundle carried through ID/EX, EX/MEM and MEM/WB.
  typedef struct packed {
    logic                 valid;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 mem_to_reg;
    logic                 alu_src;
    logic                 set_flags;
    logic [2:0]           alu_op;
    logic                 uncond_br;
    logic                 br_zero;
    logic                 br_lt;
    logic [CTRL_RD_W-1:0] rd;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: inst[31:21] to control bundle plus the
// source-operand usage needed by the load-use hazard check.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output ctrl_t       ctrl,
  output logic        reg2loc,
  output logic        illegal_dec,
  output logic        rn_src,
  output logic        p2_src
);

  // Decode table; valid and rd are filled in by the pipeline from the instruction.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    ctrl        = CTRL_BUBBLE;
    reg2loc     = 1'b0;
    illegal_dec = 1'b0;
    rn_src      = 1'b1;
    p2_src      = 1'b0;
    casez (opcode)
      OP_ADDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      OP_ADDS: begin
        ctrl.reg_write = 1'b1;
        ctrl.set_flags = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        p2_src         = 1'b1;
      end
      OP_SUBS: begin
        ctrl.reg_write = 1'b1;
        ctrl.set_flags = 1'b1;
        ctrl.alu_op    = ALU_SUB;
        p2_src         = 1'b1;
      end
      OP_MUL: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_MUL;
        p2_src         = 1'b1;
      end
      OP_LSL: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_LSL;
      end
      OP_LSR: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_LSR;
      end
      OP_B: begin
        ctrl.uncond_br = 1'b1;
        rn_src         = 1'b0;
      end
      OP_CBZ: begin
        reg2loc      = 1'b1;
        ctrl.br_zero = 1'b1;
        ctrl.alu_op  = ALU_PASSB;
        p2_src       = 1'b1;
      end
      OP_BLT: begin
        ctrl.br_lt = 1'b1;
        rn_src     = 1'b0;
      end
      OP_LDUR: begin
        reg2loc         = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_op     = ALU_ADD;
      end
      OP_STUR: begin
        reg2loc        = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        p2_src         = 1'b1;
      end
      default: illegal_dec = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline for the 5-stage core: decodes the ID instruction, carries
// the control bundle through ID/EX, EX/MEM and MEM/WB, detects load-use
// hazards and squashes the ID instruction on a taken branch.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_AW       = CTRL_RD_W,
  parameter int ZERO_REG     = 31,
  parameter bit HAZARD_EN    = 1'b1,
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst,
  input  logic        inst_valid,
  input  logic        br_taken,
  output logic        reg2loc,
  output logic        stall,
  output ctrl_t       id_ex_ctrl,
  output ctrl_t       ex_mem_ctrl,
  output ctrl_t       mem_wb_ctrl,
  output logic        illegal
);

  ctrl_t             dec_ctrl;
  ctrl_t             decoded;
  logic              illegal_dec;
  logic              rn_src;
  logic              p2_src;
  logic [REG_AW-1:0] rn_addr;
  logic [REG_AW-1:0] p2_addr;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_is_load;
  logic              src_hit;
  logic              unused_inst;

  ctrl_decode u_decode (
    .opcode      (inst[31:21]),
    .ctrl        (dec_ctrl),
    .reg2loc     (reg2loc),
    .illegal_dec (illegal_dec),
    .rn_src      (rn_src),
    .p2_src      (p2_src)
  );

  // Immediate/shift-amount bits play no part in control decode.
  assign unused_inst = ^inst[15:10];

  // Complete a recognised bundle with the instruction's valid and destination.
  always_comb begin
    decoded = dec_ctrl;
    if (!illegal_dec) begin
      decoded.valid = inst_valid;
      decoded.rd    = inst[CTRL_RD_W-1:0];
    end
  end

  // Load-use hazard: a live load in EX writing a register the ID instruction reads.
  assign rn_addr    = inst[5 +: REG_AW];
  assign p2_addr    = reg2loc ? inst[0 +: REG_AW] : inst[16 +: REG_AW];
  assign ex_rd      = id_ex_ctrl.rd[REG_AW-1:0];
  assign ex_is_load = id_ex_ctrl.valid && id_ex_ctrl.mem_read && (ex_rd != REG_AW'(ZERO_REG));
  assign src_hit    = (rn_src && (rn_addr == ex_rd)) || (p2_src && (p2_addr == ex_rd));
  assign stall      = HAZARD_EN && ex_is_load && inst_valid && src_hit;

  // Stage registers; a flush or stall inserts a bubble into ID/EX only.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_ex_ctrl  <= CTRL_BUBBLE;
      ex_mem_ctrl <= CTRL_BUBBLE;
      mem_wb_ctrl <= CTRL_BUBBLE;
    end else begin
      // NOTE: non-blocking assignments so each stage captures the previous stage's pre-edge value.
      if (br_taken || stall) begin
        id_ex_ctrl <= CTRL_BUBBLE;
      end else begin
        id_ex_ctrl <= decoded;
      end
      ex_mem_ctrl <= id_ex_ctrl;
      mem_wb_ctrl <= ex_mem_ctrl;
    end
  end

  // Sticky flag for an undecodable instruction that actually enters ID/EX.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal <= 1'b0;
    end else if (TRAP_ILLEGAL && inst_valid && illegal_dec && !br_taken && !stall) begin
      illegal <= 1'b1;
    end
  end

endmodule
